// File: rtl/cic3_echip65_row_param.sv
// Row of NUM_CH third-order CIC decimators sharing one decimation counter,
// with per-channel enable, synchronous restart and a registered monitor tap.
module cic3_echip65_row_param #(
    parameter  int NUM_CH   = 12,
    parameter  int DEC_LOG2 = 8,
    parameter  int SEL_W    = 4,
    localparam int OUT_W    = 3 * DEC_LOG2 + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       in,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic                    sync_clr,
    input  logic [SEL_W-1:0]        monitor_sel,
    output logic [NUM_CH*OUT_W-1:0] out,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        monitor_out,
    output logic                    monitor_valid
);

    typedef logic [OUT_W-1:0] word_t;

    logic [DEC_LOG2-1:0] dec_cnt_q, dec_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                monitor_valid_q, monitor_valid_d;
    word_t               monitor_q, monitor_d;

    word_t i1_q [NUM_CH];
    word_t i1_d [NUM_CH];
    word_t i2_q [NUM_CH];
    word_t i2_d [NUM_CH];
    word_t i3_q [NUM_CH];
    word_t i3_d [NUM_CH];
    word_t d1_q [NUM_CH];
    word_t d1_d [NUM_CH];
    word_t d2_q [NUM_CH];
    word_t d2_d [NUM_CH];
    word_t d3_q [NUM_CH];
    word_t d3_d [NUM_CH];
    word_t out_q [NUM_CH];
    word_t out_d [NUM_CH];
    word_t c1 [NUM_CH];
    word_t c2 [NUM_CH];
    word_t c3 [NUM_CH];

    logic dec_edge;

    assign dec_edge = &dec_cnt_q;

    // Comb section; integrator wrap is cancelled here by the modulo subtractions.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            c1[k] = i3_q[k] - d1_q[k];
            c2[k] = c1[k] - d2_q[k];
            c3[k] = c2[k] - d3_q[k];
        end
    end

    always_comb begin
        dec_cnt_d       = dec_cnt_q + DEC_LOG2'(1);
        out_valid_d     = dec_edge;
        monitor_valid_d = out_valid_q;
        monitor_d       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (monitor_sel == SEL_W'(k)) monitor_d = out_q[k];
        end

        for (int k = 0; k < NUM_CH; k++) begin
            i1_d[k]  = i1_q[k] + word_t'(in[k]);
            i2_d[k]  = i2_q[k] + i1_q[k];
            i3_d[k]  = i3_q[k] + i2_q[k];
            d1_d[k]  = d1_q[k];
            d2_d[k]  = d2_q[k];
            d3_d[k]  = d3_q[k];
            out_d[k] = out_q[k];
            if (dec_edge) begin
                d1_d[k]  = i3_q[k];
                d2_d[k]  = c1[k];
                d3_d[k]  = c2[k];
                out_d[k] = c3[k];
            end
            // A disabled channel is held at zero so it restarts cleanly on re-enable.
            if (sync_clr || !ch_enable[k]) begin
                i1_d[k]  = '0;
                i2_d[k]  = '0;
                i3_d[k]  = '0;
                d1_d[k]  = '0;
                d2_d[k]  = '0;
                d3_d[k]  = '0;
                out_d[k] = '0;
            end
        end

        if (sync_clr) begin
            dec_cnt_d       = '0;
            out_valid_d     = 1'b0;
            monitor_valid_d = 1'b0;
            monitor_d       = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_cnt_q       <= '0;
            out_valid_q     <= 1'b0;
            monitor_valid_q <= 1'b0;
            monitor_q       <= '0;
            // NOTE: these arrays are plain flops, not RAM, so resetting them is cheap and required.
            for (int k = 0; k < NUM_CH; k++) begin
                i1_q[k]  <= '0;
                i2_q[k]  <= '0;
                i3_q[k]  <= '0;
                d1_q[k]  <= '0;
                d2_q[k]  <= '0;
                d3_q[k]  <= '0;
                out_q[k] <= '0;
            end
        end else begin
            dec_cnt_q       <= dec_cnt_d;
            out_valid_q     <= out_valid_d;
            monitor_valid_q <= monitor_valid_d;
            monitor_q       <= monitor_d;
            for (int k = 0; k < NUM_CH; k++) begin
                i1_q[k]  <= i1_d[k];
                i2_q[k]  <= i2_d[k];
                i3_q[k]  <= i3_d[k];
                d1_q[k]  <= d1_d[k];
                d2_q[k]  <= d2_d[k];
                d3_q[k]  <= d3_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign out[k*OUT_W +: OUT_W] = out_q[k];
    end

    assign out_valid     = out_valid_q;
    assign monitor_out   = monitor_q;
    assign monitor_valid = monitor_valid_q;

endmodule

// File: tb/tb_cic3_echip65_row_param.sv
// Bench for the CIC3 row: spec-constant vector table, hand-written corner
// sequences, random traffic against a cumulative-sum reference model.
module tb_cic3_echip65_row_param;

    localparam int NUM_CH = 12;
    localparam int DL2    = 8;
    localparam int R      = 1 << DL2;
    localparam int OUT_W  = 3 * DL2 + 1;
    localparam int FULL   = 1 << (OUT_W - 1);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       din;
    logic [NUM_CH-1:0]       ch_enable;
    logic                    sync_clr;
    logic [3:0]              monitor_sel;
    logic [NUM_CH*OUT_W-1:0] dout;
    logic                    out_valid;
    logic [OUT_W-1:0]        monitor_out;
    logic                    monitor_valid;

    // Small instance for the parameter sweep (R = 16, OUT_W = 13).
    logic        s_rst_n;
    logic [3:0]  s_in;
    logic [3:0]  s_en;
    logic        s_clr;
    logic [1:0]  s_sel;
    logic [51:0] s_out;
    logic        s_valid;
    logic [12:0] s_mon;
    logic        s_mv;

    always #5 clk = ~clk;

    cic3_echip65_row_param #(.NUM_CH(NUM_CH), .DEC_LOG2(DL2), .SEL_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in(din), .ch_enable(ch_enable),
        .sync_clr(sync_clr), .monitor_sel(monitor_sel), .out(dout),
        .out_valid(out_valid), .monitor_out(monitor_out), .monitor_valid(monitor_valid)
    );

    cic3_echip65_row_param #(.NUM_CH(4), .DEC_LOG2(4), .SEL_W(2)) u_small (
        .clk(clk), .reset_n(s_rst_n), .in(s_in), .ch_enable(s_en),
        .sync_clr(s_clr), .monitor_sel(s_sel), .out(s_out),
        .out_valid(s_valid), .monitor_out(s_mon), .monitor_valid(s_mv)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: each channel's third running sum of its input, sampled
    // every R clocks; output is the third finite difference of the samples.
    longint           acc1 [NUM_CH];
    longint           acc2 [NUM_CH];
    longint           acc3 [NUM_CH];
    longint           hist [NUM_CH][4];
    logic [OUT_W-1:0] exp_out [NUM_CH];
    logic             exp_valid, exp_mv;
    logic [OUT_W-1:0] exp_mon;
    int               mcnt;

    task automatic model_clear_ch(input int k);
        acc1[k] = 0; acc2[k] = 0; acc3[k] = 0;
        for (int j = 0; j < 4; j++) hist[k][j] = 0;
        exp_out[k] = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) model_clear_ch(k);
        exp_valid = 1'b0; exp_mv = 1'b0; exp_mon = '0; mcnt = 0;
    endtask

    task automatic model_edge();
        logic   dec;
        longint y;
        if (sync_clr) begin
            model_reset();
            return;
        end
        exp_mv  = exp_valid;
        exp_mon = (int'(monitor_sel) < NUM_CH) ? exp_out[monitor_sel] : '0;
        dec       = (mcnt == R - 1);
        exp_valid = dec;
        mcnt      = (mcnt + 1) % R;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!ch_enable[k]) begin
                model_clear_ch(k);
            end else begin
                if (dec) begin
                    for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
                    hist[k][0] = acc3[k];
                    y = hist[k][0] - 3 * hist[k][1] + 3 * hist[k][2] - hist[k][3];
                    exp_out[k] = OUT_W'(y);
                end
                acc3[k] = acc3[k] + acc2[k];
                acc2[k] = acc2[k] + acc1[k];
                acc1[k] = acc1[k] + longint'(din[k]);
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("monitor_valid", 64'(monitor_valid), 64'(exp_mv));
        check("monitor_out", 64'(monitor_out), 64'(exp_mon));
        for (int k = 0; k < NUM_CH; k++)
            check($sformatf("out_slice%0d", k), 64'(dout[k*OUT_W +: OUT_W]), 64'(exp_out[k]));
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    typedef struct {
        string             name;
        logic [NUM_CH-1:0] in_pat;
        logic [NUM_CH-1:0] alt_mask;
        logic [NUM_CH-1:0] en;
        int                sel;
        int                cycles;
        int                chk_ch;
        int                exp_val;
    } vec_t;

    vec_t vecs [8];
    logic phase = 1'b1;

    initial begin
        int edges;
        int vcnt;
        int vt [8];
        logic [OUT_W-1:0] mon_or;

        vecs[0] = '{"ones_ch0",        12'hFFF, 12'h000, 12'hFFF, 0, 1280, 0,  FULL};
        vecs[1] = '{"ones_ch11",       12'hFFF, 12'h000, 12'hFFF, 11, 256, 11, FULL};
        vecs[2] = '{"alt_ch3",         12'h000, 12'h008, 12'hFFF, 3, 1536, 3,  FULL / 2};
        vecs[3] = '{"alt_ch0_zero",    12'h000, 12'h008, 12'hFFF, 3, 16,   0,  0};
        vecs[4] = '{"ones_ch7",        12'hFFF, 12'h000, 12'hFFF, 7, 1536, 7,  FULL};
        vecs[5] = '{"ch5_disabled",    12'hFFF, 12'h000, 12'hFDF, 5, 1000, 5,  0};
        vecs[6] = '{"ch4_while_ch5_off", 12'hFFF, 12'h000, 12'hFDF, 4, 1,  4,  FULL};
        vecs[7] = '{"ch5_reenabled",   12'hFFF, 12'h000, 12'hFFF, 5, 1280, 5,  FULL};

        reset_n = 1'b0; din = '0; ch_enable = '0; sync_clr = 1'b0; monitor_sel = '0;
        s_rst_n = 1'b0; s_in = '0; s_en = '0; s_clr = 1'b0; s_sel = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        check("reset_out_all", 64'(|dout), 64'(0));

        // First valid after reset release.
        reset_n = 1'b1; din = '1; ch_enable = '1;
        edges = 0;
        do begin
            step();
            edges++;
        end while (!out_valid && edges < 300);
        check("first_valid_cycle", 64'(edges + 1), 64'(257));

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            ch_enable   = vecs[v].en;
            monitor_sel = 4'(vecs[v].sel);
            for (int c = 0; c < vecs[v].cycles; c++) begin
                din   = vecs[v].in_pat | (vecs[v].alt_mask & {NUM_CH{phase}});
                phase = ~phase;
                step();
            end
            check(vecs[v].name, 64'(dout[vecs[v].chk_ch*OUT_W +: OUT_W]), 64'(vecs[v].exp_val));
            if (vecs[v].sel == vecs[v].chk_ch)
                check({vecs[v].name, "_mon"}, 64'(monitor_out), 64'(vecs[v].exp_val));
        end

        // sync_clr mid-frame at dec_cnt == 100.
        edges = 0;
        while (mcnt != 100 && edges < 300) begin
            step();
            edges++;
        end
        check("reach_cnt100", 64'(mcnt), 64'(100));
        sync_clr = 1'b1;
        step();
        check("clr_out_all", 64'(|dout), 64'(0));
        check("clr_valid", 64'(out_valid), 64'(0));
        sync_clr = 1'b0;
        edges = 0;
        do begin
            step();
            edges++;
        end while (!out_valid && edges < 300);
        check("clr_to_valid", 64'(edges + 1), 64'(257));

        // Out-of-range monitor select.
        monitor_sel = 4'd13;
        vcnt = 0; mon_or = '0;
        for (int c = 0; c < 512; c++) begin
            step();
            if (monitor_valid) vcnt++;
            mon_or = mon_or | monitor_out;
        end
        check("sel13_mon_zero", 64'(mon_or), 64'(0));
        check("sel13_mv_pulses", 64'(vcnt), 64'(2));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            din         = NUM_CH'($urandom);
            monitor_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) ch_enable[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            sync_clr = ($urandom_range(0, 499) == 0);
            step();
        end
        sync_clr = 1'b0;

        // Asynchronous reset in mid-cycle.
        #2 reset_n = 1'b0;
        #1;
        check("areset_valid", 64'(out_valid), 64'(0));
        check("areset_out", 64'(|dout), 64'(0));
        check("areset_mon", 64'(monitor_out), 64'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1; din = '1; ch_enable = '1;
        for (int c = 0; c < 300; c++) step();

        // Parameter sweep instance: R = 16.
        s_in = 4'hF; s_en = 4'hF; s_sel = 2'd2; s_rst_n = 1'b1;
        vcnt = 0;
        for (int e = 1; e <= 200; e++) begin
            step();
            if (s_valid) begin
                if (vcnt < 8) vt[vcnt] = e;
                vcnt++;
                if (vcnt == 4)
                    for (int k = 0; k < 4; k++)
                        check($sformatf("small_slice%0d", k), 64'(s_out[k*13 +: 13]), 64'(4096));
            end
        end
        check("small_valid_count", 64'(vcnt), 64'(12));
        check("small_first_valid", 64'(vt[0] + 1), 64'(17));
        check("small_period", 64'(vt[2] - vt[1]), 64'(16));
        check("small_mon", 64'(s_mon), 64'(4096));
        #2 s_rst_n = 1'b0;
        #1;
        check("small_areset_out", 64'(|s_out), 64'(0));
        check("small_areset_valid", 64'(s_valid | s_mv), 64'(0));
        check("small_areset_mon", 64'(s_mon), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic3_echip65_row_param.md
Name: cic3_echip65_row_param

Overview:
- Parametrised successor of the fixed 12-filter CIC3 row: NUM_CH third-order CIC decimators, each fed by its own 1-bit modulator pin.
- All channels share one clock and one decimation counter, so every channel samples on the same edge and one common out_valid strobe serves them all.
- Adds a per-channel enable mask, a synchronous restart (sync_clr) and a registered digital monitor port.
- Sits between the modulator array and the boundary output buffers.

Parameters:
- NUM_CH, 12: number of filter channels.
- DEC_LOG2, 8: log2 of the decimation ratio R (R = 2^DEC_LOG2 = 256).
- SEL_W, 4: monitor select width; must satisfy 2^SEL_W >= NUM_CH.
- OUT_W (localparam) = 3*DEC_LOG2+1, which is 25 at the defaults: output width per channel.

Ports:
- clk  input  1  common filter clock (modulator rate).
- reset_n  input  1  asynchronous reset, active low.
- in  input  NUM_CH  modulator bits; in[k] feeds channel k.
- ch_enable  input  NUM_CH  per-channel enable; 1 = run.
- sync_clr  input  1  synchronous clear of counter and all filter state.
- monitor_sel  input  SEL_W  channel routed to monitor_out.
- out  output  NUM_CH*OUT_W  channel k occupies out[(k+1)*OUT_W-1 : k*OUT_W].
- out_valid  output  1  one-cycle strobe marking new out data.
- monitor_out  output  OUT_W  registered copy of the selected channel output.
- monitor_valid  output  1  out_valid delayed by one clock.

Behaviour:
- Reset (reset_n low, asynchronous): dec_cnt, all integrator and comb registers, out, out_valid, monitor_out and monitor_valid all go to 0.
- Input mapping: in[k] is treated as unsigned 0/1 and zero-extended to OUT_W.
- Arithmetic: all arithmetic is OUT_W-bit two's complement with modulo wrap.
  - Integrator wrap is intentional; the comb stages cancel it.
  - The final result is unsigned, in the range 0..R^3. R^3 = 2^(OUT_W-1), so it fits in OUT_W bits.
- Integrators run every clk and are registered: i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2.
- Decimation counter: dec_cnt is DEC_LOG2 bits, shared by all channels, increments every clk and wraps from R-1 to 0.
- Decimation edge (dec_cnt == R-1), for each channel:
  - c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3 (combinational);
  - d1 <= i3, d2 <= c1, d3 <= c2;
  - out slice <= c3.
  - out_valid is high for exactly the one clock following that edge, i.e. one pulse per R clocks. First pulse after reset release: cycle R+1.
- out slices hold their value between decimation edges.
- Settling:
  - Constant input 1 gives outputs equal to R^3 from the 4th valid onward.
  - Constant 0 gives 0.
  - A 50% duty pattern (1010…) gives R^3/2 from the 4th valid onward.
- ch_enable[k] low: channel k's integrators, delays and out slice are synchronously cleared every clock (held at 0).
  - On re-enable the channel restarts from zero, aligned to the shared dec_cnt. Other channels are unaffected.
  - The first 3 valid outputs after re-enable are transient; the 4th and later are settled.
- sync_clr high: synchronous clear of dec_cnt, all filter state, out, out_valid and monitor registers, equivalent to reset at the next edge.
  - It has priority over the decimation edge and over ch_enable.
  - Operation resumes on the first clock with sync_clr low, with the same timing as after reset release.
- Monitor path: monitor_out <= selected out slice every clk, giving 1 clk latency from out. monitor_valid <= out_valid.
  - monitor_sel >= NUM_CH forces monitor_out to 0.
  - A monitor_sel change takes effect on the next clock edge; no glitch-free switching is required beyond register granularity.
- Reset mid-operation: immediate asynchronous clear of all state. No partial out_valid pulse may appear after reset deassertion.

Test Plan:
- Reset then in = all 1s, all channels enabled → out_valid pulses every 256 clks (first at cycle 257); every slice reads 16777216 (2^24) from the 4th valid onward.
- in[3] = 1010… pattern, other channels 0 → out slice 3 settles to 8388608; the other slices stay 0; monitor_sel = 3 gives monitor_out = 8388608 one clk after each out update.
- All 1s settled, then ch_enable[5] low for 1000 clks, then high → slice 5 reads 0 while disabled, then settles to 2^24 at the 4th valid after re-enable; the other slices never deviate from 2^24.
- sync_clr pulsed mid-frame (dec_cnt = 100) → all outputs 0 next clk; next out_valid comes exactly 257 clks after sync_clr falls.
- monitor_sel = 13 (with NUM_CH = 12) → monitor_out = 0 while monitor_valid still toggles.
- Parameter sweep NUM_CH = 4, DEC_LOG2 = 4 (OUT_W = 13), all 1s → out_valid every 16 clks; settled value 4096; reset_n asserted mid-run clears everything asynchronously.
